// File: rtl/pulse_stretcher_if.sv
// Strobe-in / level-out bundle for pulse_stretcher: the event source drives trig,
// the stretcher returns the stretched level plus busy/dropped status.
interface pulse_stretcher_if;
  logic trig;
  logic out;
  logic busy;
  logic dropped;

  modport master (
    output trig,
    input  out,
    input  busy,
    input  dropped
  );

  modport slave (
    input  trig,
    output out,
    output busy,
    output dropped
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches a trigger strobe into a STRETCH-cycle high level followed by a GAP-cycle holdoff.
// Optional build macro PULSE_STRETCHER_RETRIGGER_EN: a trig while high restarts the level.
module pulse_stretcher #(
  parameter int unsigned STRETCH = 16,
  parameter int unsigned GAP     = 4
) (
  input  logic              Clk,
  input  logic              reset,
  pulse_stretcher_if.slave  bus
);

  localparam int unsigned MaxCnt = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int unsigned CW     = (MaxCnt > 0) ? $clog2(MaxCnt + 1) : 1;

  localparam logic [CW-1:0] StretchLoad = CW'(STRETCH - 1);
  localparam logic [CW-1:0] GapLoad     = (GAP > 0) ? CW'(GAP - 1) : '0;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RetrigEn = 1'b1;
`else
  localparam bit RetrigEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StActive, StHoldoff} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            busy_q, busy_d;
  logic            dropped_q, dropped_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    busy_d    = busy_q;
    dropped_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.trig) begin
          state_d = StActive;
          cnt_d   = StretchLoad;
          out_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StActive: begin
        if (RetrigEn && bus.trig) begin
          cnt_d = StretchLoad;
        end else begin
          dropped_d = bus.trig;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            out_d = 1'b0;
            if (GAP > 0) begin
              state_d = StHoldoff;
              cnt_d   = GapLoad;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
      end
      StHoldoff: begin
        // A trig on the final holdoff edge is still refused; acceptance needs state==IDLE.
        dropped_d = bus.trig;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.busy    = busy_q;
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: a 16/4 instance and a 1/0 instance, checked against a
// remaining-cycles reference model, a vector table and a few directed sequences.
module tb_pulse_stretcher;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit Retrig = 1'b1;
`else
  localparam bit Retrig = 1'b0;
`endif

  logic Clk;
  logic reset;

  pulse_stretcher_if if_a ();
  pulse_stretcher_if if_b ();

  pulse_stretcher #(.STRETCH(16), .GAP(4)) dut_a (.Clk(Clk), .reset(reset), .bus(if_a));
  pulse_stretcher #(.STRETCH(1),  .GAP(0)) dut_b (.Clk(Clk), .reset(reset), .bus(if_b));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Model: cycles of high level / busy still owed after each edge.
  int s_par [2] = '{16, 1};
  int g_par [2] = '{4, 0};
  int out_left  [2] = '{0, 0};
  int busy_left [2] = '{0, 0};
  bit drop_m    [2] = '{0, 0};

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int k, input logic rst, input logic t);
    if (rst) begin
      out_left[k] = 0; busy_left[k] = 0; drop_m[k] = 1'b0;
    end else if (t && busy_left[k] == 0) begin
      drop_m[k] = 1'b0; out_left[k] = s_par[k]; busy_left[k] = s_par[k] + g_par[k];
    end else if (t && Retrig && out_left[k] > 0) begin
      drop_m[k] = 1'b0; out_left[k] = s_par[k]; busy_left[k] = s_par[k] + g_par[k];
    end else begin
      drop_m[k] = t && (busy_left[k] > 0);
      if (out_left[k] > 0)  out_left[k]--;
      if (busy_left[k] > 0) busy_left[k]--;
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic step(input logic rst, input logic ta, input logic tb_in);
    reset = rst;
    if_a.trig = ta;
    if_b.trig = tb_in;
    @(posedge Clk);
    model_step(0, rst, ta);
    model_step(1, rst, tb_in);
    #1;
    chk("model_a_out",  if_a.out,     out_left[0] > 0);
    chk("model_a_busy", if_a.busy,    busy_left[0] > 0);
    chk("model_a_drop", if_a.dropped, drop_m[0]);
    chk("model_b_out",  if_b.out,     out_left[1] > 0);
    chk("model_b_busy", if_b.busy,    busy_left[1] > 0);
    chk("model_b_drop", if_b.dropped, drop_m[1]);
  endtask

  typedef struct {
    logic trig;
    logic rst;
    int   cycles;
    logic e_out;
    logic e_busy;
    logic e_drop;
  } vec_t;

  vec_t tbl [17];

  int cnt_out_a, cnt_busy_a, cnt_drop_a, cnt_out_b, cnt_busy_b;

  initial begin
    reset = 1'b1;
    if_a.trig = 1'b0;
    if_b.trig = 1'b0;

    // Single pulse, then holdoff drop, exit-edge drop and acceptance in IDLE.
    tbl[0]  = '{1'b1, 1'b1, 3,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4,  1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 15, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 15, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 15, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0};

    for (int r = 0; r < 17; r++) begin
      for (int c = 0; c < tbl[r].cycles; c++) begin
        step(tbl[r].rst, tbl[r].trig, 1'b0);
        chk("tbl_out",  if_a.out,     tbl[r].e_out);
        chk("tbl_busy", if_a.busy,    tbl[r].e_busy);
        chk("tbl_drop", if_a.dropped, tbl[r].e_drop);
      end
    end

    // Second trig five cycles into ACTIVE.
    cnt_out_a = 0; cnt_drop_a = 0;
    for (int i = 0; i < 31; i++) begin
      step(1'b0, (i == 0 || i == 5), 1'b0);
      cnt_out_a  += int'(if_a.out);
      cnt_drop_a += int'(if_a.dropped);
    end
    chk_int("retrig_out_width", cnt_out_a, Retrig ? 21 : 16);
    chk_int("retrig_drops", cnt_drop_a, Retrig ? 0 : 1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

    // Level trig held 40 cycles.
    cnt_out_a = 0; cnt_busy_a = 0; cnt_drop_a = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, (i < 40), 1'b0);
      cnt_out_a  += int'(if_a.out);
      cnt_busy_a += int'(if_a.busy);
      cnt_drop_a += int'(if_a.dropped);
    end
    chk_int("level_out_cycles",  cnt_out_a,  Retrig ? 55 : 32);
    chk_int("level_busy_cycles", cnt_busy_a, Retrig ? 59 : 40);
    chk_int("level_drops",       cnt_drop_a, Retrig ? 0 : 38);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

    // Reset mid-ACTIVE, then a fresh trigger on both instances.
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_mid_a_out",  if_a.out,  1'b0);
    chk("rst_mid_a_busy", if_a.busy, 1'b0);
    chk("rst_mid_b_out",  if_b.out,  1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cnt_out_a = 0; cnt_busy_a = 0; cnt_out_b = 0; cnt_busy_b = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b0, (i == 0), (i == 0));
      cnt_out_a  += int'(if_a.out);
      cnt_busy_a += int'(if_a.busy);
      cnt_out_b  += int'(if_b.out);
      cnt_busy_b += int'(if_b.busy);
    end
    chk_int("post_rst_a_out",  cnt_out_a,  16);
    chk_int("post_rst_a_busy", cnt_busy_a, 20);
    chk_int("post_rst_b_out",  cnt_out_b,  1);
    chk_int("post_rst_b_busy", cnt_busy_b, 1);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 25), ($urandom_range(99) < 45));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
